matmul_req_arbiter: RTL and testbench

Round-robin scheduler that shares a single `matmul_2x2_kN` engine between `NREQ` requesters. It accepts one job at a time (2x2 A and B operands) through a valid/ready handshake, latches the operands, and drives and holds the engine's level-sensitive `start` until `done`. It then captures C and returns the result to the granted requester through a valid/ready response. A watchdog aborts jobs whose engine never signals `done`.

---
 rtl/matmul_req_arbiter.sv | 154 +++++++++++++++
 tb/tb_matmul_req_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_req_arbiter.sv
// matmul_req_arbiter: round-robin front end that shares one 2x2 matmul engine
// between NREQ requesters. One job in flight; operands are latched on accept,
// engine start is held until done, and the result (or a watchdog abort) is
// returned to the owning requester through a valid/ready response.
module matmul_req_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NREQ-1:0]                        i_req_valid,
    output logic [NREQ-1:0]                        o_req_ready,
    input  logic [NREQ-1:0][1:0][1:0][DATA_W-1:0]  i_req_a,
    input  logic [NREQ-1:0][1:0][1:0][DATA_W-1:0]  i_req_b,
    output logic [NREQ-1:0]                        o_rsp_valid,
    input  logic [NREQ-1:0]                        i_rsp_ready,
    output logic [1:0][1:0][ACC_W-1:0]             o_rsp_c,
    output logic                                   o_rsp_err,
    output logic                                   o_eng_start,
    output logic [1:0][1:0][DATA_W-1:0]            o_eng_a,
    output logic [1:0][1:0][DATA_W-1:0]            o_eng_b,
    input  logic [1:0][1:0][ACC_W-1:0]             i_eng_c,
    input  logic                                   i_eng_done,
    output logic                                   o_busy,
    output logic [$clog2(NREQ)-1:0]                o_grant_id
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RESP
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [IDW-1:0]                r_last;
    logic [IDW-1:0]                r_grant;
    logic [WDW-1:0]                r_wdog;
    logic                          r_eng_start;
    logic [1:0][1:0][DATA_W-1:0]   r_eng_a;
    logic [1:0][1:0][DATA_W-1:0]   r_eng_b;
    logic [1:0][1:0][ACC_W-1:0]    r_rsp_c;
    logic                          r_rsp_err;

    logic [IDW-1:0]                w_cand;
    logic [IDW-1:0]                w_pick_id;
    logic                          w_pick_valid;
    logic                          w_accept;
    logic                          w_timeout;
    logic                          w_rsp_done;

    // Round-robin search: first valid requester after the last grant, with wrap
    always_comb begin
        w_cand       = '0;
        w_pick_id    = '0;
        w_pick_valid = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IDW'((int'(r_last) + i) % NREQ);
            if (!w_pick_valid && i_req_valid[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_id    = w_cand;
            end
        end
    end

    assign w_accept   = rst_n && (r_state == S_IDLE) && w_pick_valid;
    assign w_timeout  = (r_wdog == WDW'(TIMEOUT - 1));
    assign w_rsp_done = (r_state == S_RESP) && i_rsp_ready[r_grant];

    // Handshake decode: ready only to the chosen requester, valid only to the owner
    always_comb begin
        o_req_ready = '0;
        o_rsp_valid = '0;
        if (w_accept) begin
            o_req_ready[w_pick_id] = 1'b1;
        end
        if (r_state == S_RESP) begin
            o_rsp_valid[r_grant] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; done takes precedence over a coincident watchdog expiry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_START;
            S_START: if (i_eng_done || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Accept path: latch operands and owner, arm engine start, clear the watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eng_a <= '0;
            r_eng_b <= '0;
            r_grant <= '0;
            r_last  <= IDW'(NREQ - 1);
        end else if (w_accept) begin
            r_eng_a <= i_req_a[w_pick_id];
            r_eng_b <= i_req_b[w_pick_id];
            r_grant <= w_pick_id;
            r_last  <= w_pick_id;
        end
    end

    // Run path: hold start, count the watchdog, capture result or abort
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eng_start <= 1'b0;
            r_wdog      <= '0;
            r_rsp_c     <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_eng_start <= 1'b1;
            r_wdog      <= '0;
        end else if (r_state == S_START) begin
            r_wdog <= r_wdog + WDW'(1);
            if (i_eng_done) begin
                r_rsp_c     <= i_eng_c;
                r_rsp_err   <= 1'b0;
                r_eng_start <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_c     <= '0;
                r_rsp_err   <= 1'b1;
                r_eng_start <= 1'b0;
            end
        end
    end

    assign o_eng_start = r_eng_start;
    assign o_eng_a     = r_eng_a;
    assign o_eng_b     = r_eng_b;
    assign o_rsp_c     = r_rsp_c;
    assign o_rsp_err   = r_rsp_err;
    assign o_busy      = (r_state != S_IDLE);
    assign o_grant_id  = r_grant;

endmodule

// File: tb/tb_matmul_req_arbiter.sv
// tb_matmul_req_arbiter: scoreboard bench for matmul_req_arbiter with a
// behavioural engine stub (depth K, optional hang to exercise the watchdog).
module tb_matmul_req_arbiter;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 32;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam int K       = 2;

    typedef logic [1:0][1:0][DATA_W-1:0] mat_t;
    typedef logic [1:0][1:0][ACC_W-1:0]  cmat_t;
    typedef struct {
        int    id;
        cmat_t c;
        logic  err;
    } exp_t;

    logic                                  clk = 1'b0;
    logic                                  rst_n;
    logic [NREQ-1:0]                       reqValid;
    logic [NREQ-1:0]                       reqReady;
    logic [NREQ-1:0][1:0][1:0][DATA_W-1:0] reqA;
    logic [NREQ-1:0][1:0][1:0][DATA_W-1:0] reqB;
    logic [NREQ-1:0]                       rspValid;
    logic [NREQ-1:0]                       rspReady;
    cmat_t                                 rspC;
    logic                                  rspErr;
    logic                                  engStart;
    mat_t                                  engA;
    mat_t                                  engB;
    cmat_t                                 engC;
    logic                                  engDone;
    logic                                  busy;
    logic [$clog2(NREQ)-1:0]               grantId;

    int   cycle = 0;
    int   engCnt;
    logic engHang;
    int   nCompared = 0;
    int   nMismatched = 0;
    exp_t sbq[$];

    matmul_req_arbiter #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(reqValid), .o_req_ready(reqReady),
        .i_req_a(reqA), .i_req_b(reqB),
        .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
        .o_rsp_c(rspC), .o_rsp_err(rspErr),
        .o_eng_start(engStart), .o_eng_a(engA), .o_eng_b(engB),
        .i_eng_c(engC), .i_eng_done(engDone),
        .o_busy(busy), .o_grant_id(grantId)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic cmat_t matMul(input mat_t a, input mat_t b);
        cmat_t c;
        int s;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++) begin
                    s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
                end
                c[i][j] = s;
            end
        end
        return c;
    endfunction

    function automatic mat_t mk(input int a00, input int a01, input int a10, input int a11);
        mat_t m;
        m[0][0] = a00[DATA_W-1:0];
        m[0][1] = a01[DATA_W-1:0];
        m[1][0] = a10[DATA_W-1:0];
        m[1][1] = a11[DATA_W-1:0];
        return m;
    endfunction

    function automatic cmat_t mkC(input int c00, input int c01, input int c10, input int c11);
        cmat_t m;
        m[0][0] = c00;
        m[0][1] = c01;
        m[1][0] = c10;
        m[1][1] = c11;
        return m;
    endfunction

    // Engine stub: done appears K+3 cycles after start rises, drops the edge after start falls
    always @(posedge clk) begin
        if (!rst_n || !engStart) begin
            engCnt  <= 0;
            engDone <= 1'b0;
        end else begin
            engCnt <= engCnt + 1;
            if (engCnt == K + 2 && !engHang) engDone <= 1'b1;
        end
    end

    assign engC = engDone ? matMul(engA, engB) : {4{32'h0BAD_0BAD}};

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Response monitor: pops the scoreboard on each response handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ((rspValid & rspReady) != '0)) begin
            if (sbq.size() == 0) begin
                checkOutput("spuriousRsp", 1, 0);
            end else begin
                e = sbq.pop_front();
                checkOutput("rspOwner", rspValid, 128'(1) << e.id);
                checkOutput("rspC", rspC, e.c);
                checkOutput("rspErr", rspErr, e.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int id, input mat_t a, input mat_t b, input logic err, output int tAcc);
        exp_t e;
        bit   got;
        got  = 1'b0;
        tAcc = -1;
        reqA[id] = a;
        reqB[id] = b;
        reqValid[id] = 1'b1;
        #1;
        for (int n = 0; n < 100 && !got; n++) begin
            if (reqReady[id]) begin
                got   = 1'b1;
                tAcc  = cycle;
                e.id  = id;
                e.c   = err ? '0 : matMul(a, b);
                e.err = err;
                sbq.push_back(e);
            end
            tick();
        end
        reqValid[id] = 1'b0;
        if (!got) checkOutput("acceptTimeout", 0, 1);
    endtask

    task automatic waitRsp(output int tRise, output int startCycles);
        tRise = -1;
        startCycles = 0;
        for (int n = 0; n < 200; n++) begin
            if (rspValid != '0) begin
                tRise = cycle;
                break;
            end
            if (engStart) startCycles++;
            tick();
        end
        checkOutput("rspSeen", tRise >= 0, 1);
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 200; n++) begin
            if (sbq.size() == 0 && !busy) break;
            tick();
        end
        checkOutput("drain", (sbq.size() == 0) && !busy, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: observed no finish required finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int   tAcc;
        int   tRise;
        int   sc;
        int   id;
        bit   got;
        exp_t e;
        mat_t mA;
        mat_t mB;
        mat_t mNegI;
        mat_t mI;
        mat_t mMin;

        mA    = mk(1, 2, 3, 4);
        mB    = mk(5, 6, 7, 8);
        mNegI = mk(-1, 0, 0, -1);
        mI    = mk(1, 0, 0, 1);
        mMin  = mk(-128, -128, -128, -128);

        rst_n    = 1'b0;
        reqValid = '1;
        rspReady = '0;
        reqA     = '0;
        reqB     = '0;
        engHang  = 1'b0;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rstReqReady", reqReady, 0);
        checkOutput("rstRspValid", rspValid, 0);
        checkOutput("rstEngStart", engStart, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstEngA", engA, 0);
        checkOutput("rstEngB", engB, 0);
        checkOutput("rstRspC", rspC, 0);
        checkOutput("rstRspErr", rspErr, 0);
        checkOutput("rstGrant", grantId, 0);
        reqValid = '0;
        rst_n    = 1'b1;
        tick();

        $display("[TB] single job");
        rspReady = '1;
        applyStimulus(0, mA, mB, 1'b0, tAcc);
        waitRsp(tRise, sc);
        checkOutput("singleLatency", tRise - tAcc, 7);
        checkOutput("singleStartCycles", sc, 6);
        checkOutput("singleStartFall", engStart, 0);
        checkOutput("singleC", rspC, mkC(19, 22, 43, 50));
        waitDrain();

        $display("[TB] signed extremes");
        applyStimulus(1, mMin, mMin, 1'b0, tAcc);
        waitRsp(tRise, sc);
        checkOutput("extremeC", rspC, mkC(32768, 32768, 32768, 32768));
        waitDrain();

        $display("[TB] round robin");
        reqA[0] = mA;    reqB[0] = mB;
        reqA[1] = mNegI; reqB[1] = mI;
        reqValid = '1;
        #1;
        for (int j = 0; j < 4; j++) begin
            got = 1'b0;
            for (int n = 0; n < 100 && !got; n++) begin
                if (reqReady != '0) begin
                    got = 1'b1;
                    id  = reqReady[1] ? 1 : 0;
                    checkOutput("rrGrant", id, j % 2);
                    e.id  = id;
                    e.c   = (id == 0) ? matMul(mA, mB) : mkC(-1, 0, 0, -1);
                    e.err = 1'b0;
                    sbq.push_back(e);
                end
                tick();
            end
            if (j == 3) reqValid = '0;
            if (!got) checkOutput("rrTimeout", 0, 1);
            checkOutput("rrGrantId", grantId, j % 2);
        end
        waitDrain();

        $display("[TB] response backpressure");
        rspReady = '0;
        applyStimulus(0, mA, mB, 1'b0, tAcc);
        waitRsp(tRise, sc);
        checkOutput("bpLatency", tRise - tAcc, 7);
        reqA[1] = mNegI; reqB[1] = mI;
        reqValid[1] = 1'b1;
        rspReady[1] = 1'b1;
        #1;
        for (int n = 0; n < 11; n++) begin
            checkOutput("bpRspValid", rspValid, 2'b01);
            checkOutput("bpRspC", rspC, mkC(19, 22, 43, 50));
            checkOutput("bpReqReady", reqReady, 0);
            checkOutput("bpEngStart", engStart, 0);
            tick();
        end
        reqValid = '0;
        rspReady = '1;
        tick();
        checkOutput("bpReleased", busy, 0);
        waitDrain();

        $display("[TB] watchdog");
        engHang = 1'b1;
        applyStimulus(1, mA, mB, 1'b1, tAcc);
        waitRsp(tRise, sc);
        checkOutput("wdLatency", tRise - tAcc, TIMEOUT + 1);
        checkOutput("wdErr", rspErr, 1);
        checkOutput("wdC", rspC, 0);
        waitDrain();
        engHang = 1'b0;
        applyStimulus(0, mNegI, mB, 1'b0, tAcc);
        waitRsp(tRise, sc);
        checkOutput("wdNextLatency", tRise - tAcc, 7);
        checkOutput("wdNextErr", rspErr, 0);
        waitDrain();

        $display("[TB] reset mid-job");
        applyStimulus(0, mA, mB, 1'b0, tAcc);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstEngStart", engStart, 0);
        checkOutput("midRstEngA", engA, 0);
        checkOutput("midRstEngB", engB, 0);
        checkOutput("midRstRspC", rspC, 0);
        checkOutput("midRstRspErr", rspErr, 0);
        checkOutput("midRstRspValid", rspValid, 0);
        checkOutput("midRstGrant", grantId, 0);
        sbq.delete();
        rst_n = 1'b1;
        tick();
        for (int n = 0; n < 20; n++) begin
            checkOutput("midRstNoRsp", rspValid, 0);
            tick();
        end
        reqA[0] = mA;    reqB[0] = mB;
        reqA[1] = mNegI; reqB[1] = mI;
        reqValid = '1;
        #1;
        checkOutput("midRstPriority", reqReady, 2'b01);
        e.id  = 0;
        e.c   = matMul(mA, mB);
        e.err = 1'b0;
        sbq.push_back(e);
        tick();
        reqValid = '0;
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
